pcie_7x_link_seq: RTL and testbench

Bring-up and recovery sequencer for the 7-series PCIe AXI-MM core, for boards where the core's `sys_rst_n` is not wired to a slot reset. It holds the core in reset for a programmed power-up interval, then releases it and waits for link-up with a timeout. It also:
- debounces link-up,
- retries with bounded attempts,
- drives the status LEDs.

It sits in the board top between free-running clock/reset logic and the core's `sys_rst_n`/`user_lnk_up` pins.

---
 rtl/pcie_7x_link_seq.sv | 174 +++++++++++++++++
 tb/tb_pcie_7x_link_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_7x_link_seq.sv
// Bring-up / recovery sequencer for the 7-series PCIe core's sys_rst_n.
// Holds the core in reset, releases it, waits for a debounced link with a
// timeout, retries a bounded number of times, and drives the status LEDs.
module pcie_7x_link_seq #(
  parameter int unsigned PWRUP_CYCLES  = 1024,
  parameter int unsigned LINK_TIMEOUT  = 1048576,
  parameter int unsigned LINKUP_STABLE = 256,
  parameter int unsigned MAX_RETRY     = 7,
  parameter int unsigned BLINK_DIV     = 16777216
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       user_lnk_up,
  input  logic       sw_reset_req,
  output logic       core_rst_n,
  output logic       link_ok,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state,
  output logic [2:0] led
);

  localparam int unsigned HoldW  = $clog2(PWRUP_CYCLES + 1);
  localparam int unsigned ToW    = $clog2(LINK_TIMEOUT + 1);
  localparam int unsigned StbW   = $clog2(LINKUP_STABLE + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV + 1);

  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(PWRUP_CYCLES - 1);
  localparam logic [ToW-1:0]    ToLast    = ToW'(LINK_TIMEOUT - 1);
  localparam logic [StbW-1:0]   StbLast   = StbW'(LINKUP_STABLE - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
  localparam logic [3:0]        RetryMax  = 4'(MAX_RETRY);

  localparam logic [2:0] StResetHold = 3'd0;
  localparam logic [2:0] StWaitLink  = 3'd1;
  localparam logic [2:0] StStable    = 3'd2;
  localparam logic [2:0] StUp        = 3'd3;
  localparam logic [2:0] StFail      = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d, hold_inc;
  logic [ToW-1:0]    to_q, to_d, to_inc;
  logic [StbW-1:0]   stb_q, stb_d, stb_inc;
  logic [3:0]        retry_q, retry_d;
  logic [BlinkW-1:0] blink_q;
  logic              hb_q;
  logic              crn_q;
  logic              lnk_meta, lnk_s;
  logic              timeout, stb_done;

  // Two-flop synchronizer for the asynchronous link-up status.
  always_ff @(posedge clk) begin
    if (rst) begin
      lnk_meta <= 1'b0;
      lnk_s    <= 1'b0;
    end else begin
      lnk_meta <= user_lnk_up;
      lnk_s    <= lnk_meta;
    end
  end

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign hold_inc = (&hold_q) ? hold_q : hold_q + 1'b1;
  assign to_inc   = (&to_q)   ? to_q   : to_q + 1'b1;
  assign stb_inc  = (&stb_q)  ? stb_q  : stb_q + 1'b1;

  assign timeout  = (to_q == ToLast);
  assign stb_done = lnk_s && (stb_q == StbLast);

  // Next-state logic; stable completion beats timeout, which beats link drop.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    to_d    = to_q;
    stb_d   = stb_q;
    retry_d = retry_q;
    unique case (state_q)
      StResetHold: begin
        hold_d = hold_inc;
        if (hold_q == HoldLast) begin
          state_d = StWaitLink;
          to_d    = '0;
        end
      end
      StWaitLink, StStable: begin
        to_d = to_inc;
        if (state_q == StStable && lnk_s) stb_d = stb_inc;
        if (state_q == StStable && stb_done) begin
          state_d = StUp;
          retry_d = '0;
        end else if (timeout) begin
          if (retry_q == RetryMax) begin
            state_d = StFail;
          end else begin
            state_d = StResetHold;
            retry_d = retry_q + 4'd1;
            hold_d  = '0;
          end
        end else if (state_q == StWaitLink && lnk_s) begin
          state_d = StStable;
          stb_d   = '0;
        end else if (state_q == StStable && !lnk_s) begin
          state_d = StWaitLink;
        end
      end
      StUp: begin
        if (!lnk_s) begin
          state_d = StResetHold;
          hold_d  = '0;
        end
      end
      StFail: begin
        state_d = StFail;
      end
      default: begin
        state_d = StResetHold;
        hold_d  = '0;
      end
    endcase
    if (sw_reset_req) begin
      state_d = StResetHold;
      retry_d = '0;
      hold_d  = '0;
      to_d    = '0;
    end
  end

  // Sequencer state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StResetHold;
      hold_q  <= '0;
      to_q    <= '0;
      stb_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
      stb_q   <= stb_d;
      retry_q <= retry_d;
    end
  end

  // Core reset is registered from the next state so it tracks the state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      crn_q <= 1'b0;
    end else begin
      crn_q <= (state_d == StWaitLink) || (state_d == StStable) || (state_d == StUp);
    end
  end

  // Free-running heartbeat, independent of the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= '0;
      hb_q    <= 1'b0;
    end else if (blink_q == BlinkLast) begin
      blink_q <= '0;
      hb_q    <= ~hb_q;
    end else begin
      blink_q <= blink_q + 1'b1;
    end
  end

  assign core_rst_n = crn_q;
  assign link_ok    = (state_q == StUp);
  assign fail       = (state_q == StFail);
  assign retry_cnt  = retry_q;
  assign state      = state_q;
  assign led        = {fail, hb_q, link_ok};

endmodule

// File: tb/tb_pcie_7x_link_seq.sv
// Self-checking bench for pcie_7x_link_seq: directed scenarios, a cycle model
// of the sequencing rules compared every cycle, plus hand-computed pin points.
module tb_pcie_7x_link_seq;

  localparam int PW = 16;
  localparam int LT = 100;
  localparam int LS = 8;
  localparam int MR = 2;
  localparam int BD = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       lnk_in;
  logic       sw_req;
  logic       core_rst_n;
  logic       link_ok;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;
  logic [2:0] led;

  pcie_7x_link_seq #(
    .PWRUP_CYCLES (PW),
    .LINK_TIMEOUT (LT),
    .LINKUP_STABLE(LS),
    .MAX_RETRY    (MR),
    .BLINK_DIV    (BD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .user_lnk_up (lnk_in),
    .sw_reset_req(sw_req),
    .core_rst_n  (core_rst_n),
    .link_ok     (link_ok),
    .fail        (fail),
    .retry_cnt   (retry_cnt),
    .state       (state),
    .led         (led)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Model: state number (0 hold, 1 wait, 2 stable, 3 up, 4 fail) and counters.
  int m_state, m_hold, m_to, m_stb, m_retry, m_blink, m_hb, m_s1, m_s2, m_crn;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Advances the model across one rising edge using the inputs held this cycle.
  task automatic model_step();
    int  lnk;
    bit  done, tmo;
    if (rst) begin
      m_state = 0; m_hold = 0; m_to = 0; m_stb = 0; m_retry = 0;
      m_blink = 0; m_hb = 0; m_s1 = 0; m_s2 = 0; m_crn = 0;
      return;
    end
    lnk  = m_s2;
    m_s2 = m_s1;
    m_s1 = int'(lnk_in);
    if (m_blink == BD - 1) begin
      m_blink = 0;
      m_hb    = 1 - m_hb;
    end else begin
      m_blink++;
    end
    if (sw_req) begin
      m_state = 0; m_retry = 0; m_hold = 0; m_to = 0;
    end else if (m_state == 0) begin
      if (m_hold == PW - 1) begin
        m_state = 1;
        m_to    = 0;
      end else begin
        m_hold++;
      end
    end else if (m_state == 1 || m_state == 2) begin
      done = (m_state == 2) && (lnk == 1) && (m_stb == LS - 1);
      tmo  = (m_to == LT - 1);
      m_to++;
      if (m_state == 2 && lnk == 1) m_stb++;
      if (done) begin
        m_state = 3;
        m_retry = 0;
      end else if (tmo) begin
        if (m_retry == MR) begin
          m_state = 4;
        end else begin
          m_retry++;
          m_state = 0;
          m_hold  = 0;
        end
      end else if (m_state == 1 && lnk == 1) begin
        m_state = 2;
        m_stb   = 0;
      end else if (m_state == 2 && lnk == 0) begin
        m_state = 1;
      end
    end else if (m_state == 3) begin
      if (lnk == 0) begin
        m_state = 0;
        m_hold  = 0;
      end
    end
    m_crn = (m_state >= 1 && m_state <= 3) ? 1 : 0;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", int'(state), m_state);
      check("core_rst_n", int'(core_rst_n), m_crn);
      check("link_ok", int'(link_ok), (m_state == 3) ? 1 : 0);
      check("fail", int'(fail), (m_state == 4) ? 1 : 0);
      check("retry_cnt", int'(retry_cnt), m_retry);
      check("led", int'(led), ((m_state == 4) ? 4 : 0) + 2 * m_hb + ((m_state == 3) ? 1 : 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // After this, the current cycle is cycle 0: the first with rst low.
  task automatic do_reset();
    rst    = 1'b1;
    lnk_in = 1'b0;
    sw_req = 1'b0;
    tick();
    tick();
    rst    = 1'b0;
    cyc    = 0;
    chk_en = 1'b1;
  endtask

  initial begin
    rst    = 1'b1;
    lnk_in = 1'b0;
    sw_req = 1'b0;

    // Clean bring-up with heartbeat, then link loss in UP and relink.
    do_reset();
    check("lit_reset_state", int'(state), 0);
    check("lit_reset_led", int'(led), 0);
    run_to(15); check("lit_crn_15", int'(core_rst_n), 0);
    run_to(16); check("lit_crn_16", int'(core_rst_n), 1);
    check("lit_state_16", int'(state), 1);
    run_to(31); check("lit_hb_31", int'(led[1]), 0);
    run_to(32); check("lit_hb_32", int'(led[1]), 1);
    run_to(40); lnk_in = 1'b1;
    run_to(42); check("lit_state_42", int'(state), 1);
    run_to(43); check("lit_state_43", int'(state), 2);
    run_to(50); check("lit_linkok_50", int'(link_ok), 0);
    run_to(51); check("lit_linkok_51", int'(link_ok), 1);
    check("lit_led0_51", int'(led[0]), 1);
    check("lit_retry_51", int'(retry_cnt), 0);
    run_to(64); check("lit_hb_64", int'(led[1]), 0);
    run_to(70); lnk_in = 1'b0;
    run_to(72); check("lit_linkok_72", int'(link_ok), 1);
    run_to(73); check("lit_linkok_73", int'(link_ok), 0);
    check("lit_crn_73", int'(core_rst_n), 0);
    run_to(88); check("lit_crn_88", int'(core_rst_n), 0);
    run_to(89); check("lit_crn_89", int'(core_rst_n), 1);
    run_to(95); lnk_in = 1'b1;
    run_to(98); check("lit_state_98", int'(state), 2);
    run_to(106); check("lit_state_106", int'(state), 3);
    check("lit_retry_106", int'(retry_cnt), 0);

    // Flap during STABLE.
    do_reset();
    run_to(40); lnk_in = 1'b1;
    run_to(45); lnk_in = 1'b0;
    run_to(47); check("lit_flap_47", int'(state), 2);
    run_to(48); lnk_in = 1'b1;
    check("lit_flap_48", int'(state), 1);
    run_to(51); check("lit_flap_51", int'(state), 2);
    run_to(58); check("lit_flap_58", int'(link_ok), 0);
    run_to(59); check("lit_flap_59", int'(state), 3);

    // Stable completion lands on the timeout cycle: completion wins.
    do_reset();
    run_to(105); lnk_in = 1'b1;
    run_to(108); check("lit_tie_108", int'(state), 2);
    run_to(116); check("lit_tie_116", int'(state), 3);
    check("lit_tie_retry", int'(retry_cnt), 0);

    // One cycle too late: timeout, retry, then up with retry cleared.
    do_reset();
    run_to(106); lnk_in = 1'b1;
    run_to(109); check("lit_late_109", int'(state), 2);
    run_to(116); check("lit_late_116", int'(state), 0);
    check("lit_late_retry", int'(retry_cnt), 1);
    run_to(140); check("lit_late_140", int'(state), 2);
    run_to(141); check("lit_late_141", int'(state), 3);
    check("lit_late_retry2", int'(retry_cnt), 0);

    // No link: retries exhaust into FAIL, then software recovery.
    do_reset();
    run_to(115); check("lit_nl_115", int'(state), 1);
    run_to(116); check("lit_nl_116", int'(retry_cnt), 1);
    run_to(232); check("lit_nl_232", int'(retry_cnt), 2);
    run_to(347); check("lit_nl_347", int'(state), 1);
    run_to(348); check("lit_nl_348", int'(state), 4);
    check("lit_nl_fail", int'(fail), 1);
    check("lit_nl_led2", int'(led[2]), 1);
    check("lit_nl_crn", int'(core_rst_n), 0);
    run_to(1348); check("lit_nl_crn_1348", int'(core_rst_n), 0);
    sw_req = 1'b1;
    run_to(1349); sw_req = 1'b0;
    check("lit_rec_state", int'(state), 0);
    check("lit_rec_fail", int'(fail), 0);
    check("lit_rec_retry", int'(retry_cnt), 0);
    run_to(1364); check("lit_rec_crn_1364", int'(core_rst_n), 0);
    run_to(1365); check("lit_rec_crn_1365", int'(core_rst_n), 1);

    // Reset mid-WAIT_LINK (to_cnt = 50), sw restart in hold, heartbeat.
    do_reset();
    run_to(66); check("lit_mid_crn_66", int'(core_rst_n), 1);
    rst = 1'b1;
    run_to(67); rst = 1'b0;
    check("lit_mid_state", int'(state), 0);
    check("lit_mid_crn", int'(core_rst_n), 0);
    check("lit_mid_led", int'(led), 0);
    cyc = 0;
    run_to(10); sw_req = 1'b1;
    run_to(11); sw_req = 1'b0;
    check("lit_sw_state_11", int'(state), 0);
    run_to(26); check("lit_sw_crn_26", int'(core_rst_n), 0);
    run_to(27); check("lit_sw_crn_27", int'(core_rst_n), 1);
    run_to(31); check("lit_hb2_31", int'(led[1]), 0);
    run_to(32); check("lit_hb2_32", int'(led[1]), 1);
    run_to(63); check("lit_hb2_63", int'(led[1]), 1);
    run_to(64); check("lit_hb2_64", int'(led[1]), 0);
    run_to(70);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
